// File: rtl/fmrv32im_axi_arb_pkg.sv
// Shared types and AXI encodings for the two-requester AXI burst arbiter.
package fmrv32im_axi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Requester 0 is the instruction cache, requester 1 the data cache.
  localparam logic REQ_IMEM = 1'b0;
  localparam logic REQ_DMEM = 1'b1;

endpackage

// File: rtl/fmrv32im_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time is chosen.
module fmrv32im_rr_arb2
  import fmrv32im_axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Alternate on contention, otherwise take whichever requester is asking
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = REQ_IMEM;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else if (req[REQ_DMEM]) begin
      gnt_idx = REQ_DMEM;
    end
  end

endmodule

// File: rtl/fmrv32im_axi_arbiter.sv
// Shares the single MM_AXI master port between the I-cache and D-cache refill/writeback
// requesters, one INCR burst of 32-bit beats outstanding at a time.
module fmrv32im_axi_arbiter
  import fmrv32im_axi_arb_pkg::*;
#(
  parameter int   N_REQ  = 2,
  parameter logic AXI_ID = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_write,
  input  logic [N_REQ*32-1:0]  req_addr,
  input  logic [N_REQ*8-1:0]   req_len,
  input  logic [N_REQ*32-1:0]  wr_data,
  input  logic [N_REQ*4-1:0]   wr_strb,
  input  logic [N_REQ-1:0]     wr_valid,
  output logic [N_REQ-1:0]     wr_ready,
  output logic [31:0]          rd_data,
  output logic [N_REQ-1:0]     rd_valid,
  output logic                 rd_last,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [31:0]          MM_AXI_AWADDR,
  output logic [7:0]           MM_AXI_AWLEN,
  output logic                 MM_AXI_AWVALID,
  input  logic                 MM_AXI_AWREADY,
  output logic                 MM_AXI_AWID,
  output logic [2:0]           MM_AXI_AWSIZE,
  output logic [1:0]           MM_AXI_AWBURST,
  output logic                 MM_AXI_AWLOCK,
  output logic [3:0]           MM_AXI_AWCACHE,
  output logic [2:0]           MM_AXI_AWPROT,
  output logic [3:0]           MM_AXI_AWQOS,
  output logic                 MM_AXI_AWUSER,
  output logic [31:0]          MM_AXI_WDATA,
  output logic [3:0]           MM_AXI_WSTRB,
  output logic                 MM_AXI_WLAST,
  output logic                 MM_AXI_WVALID,
  input  logic                 MM_AXI_WREADY,
  input  logic [1:0]           MM_AXI_BRESP,
  input  logic                 MM_AXI_BVALID,
  output logic                 MM_AXI_BREADY,
  output logic [31:0]          MM_AXI_ARADDR,
  output logic [7:0]           MM_AXI_ARLEN,
  output logic                 MM_AXI_ARVALID,
  input  logic                 MM_AXI_ARREADY,
  output logic                 MM_AXI_ARID,
  output logic [2:0]           MM_AXI_ARSIZE,
  output logic [1:0]           MM_AXI_ARBURST,
  output logic                 MM_AXI_ARLOCK,
  output logic [3:0]           MM_AXI_ARCACHE,
  output logic [2:0]           MM_AXI_ARPROT,
  output logic [3:0]           MM_AXI_ARQOS,
  output logic                 MM_AXI_ARUSER,
  input  logic [31:0]          MM_AXI_RDATA,
  input  logic [1:0]           MM_AXI_RRESP,
  input  logic                 MM_AXI_RLAST,
  input  logic                 MM_AXI_RVALID,
  output logic                 MM_AXI_RREADY
);

  state_t      state, state_n;
  logic        gnt, last_grant;
  logic [7:0]  cnt;
  logic        err_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic        arb_valid, arb_idx;
  logic        grant_fire, cnt_inc, err_set;

  fmrv32im_rr_arb2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx)
  );

  assign MM_AXI_AWID    = AXI_ID;
  assign MM_AXI_ARID    = AXI_ID;
  assign MM_AXI_AWSIZE  = AXI_SIZE_4B;
  assign MM_AXI_ARSIZE  = AXI_SIZE_4B;
  assign MM_AXI_AWBURST = AXI_BURST_INCR;
  assign MM_AXI_ARBURST = AXI_BURST_INCR;
  assign MM_AXI_AWLOCK  = 1'b0;
  assign MM_AXI_ARLOCK  = 1'b0;
  assign MM_AXI_AWCACHE = 4'd0;
  assign MM_AXI_ARCACHE = 4'd0;
  assign MM_AXI_AWPROT  = 3'd0;
  assign MM_AXI_ARPROT  = 3'd0;
  assign MM_AXI_AWQOS   = 4'd0;
  assign MM_AXI_ARQOS   = 4'd0;
  assign MM_AXI_AWUSER  = 1'b0;
  assign MM_AXI_ARUSER  = 1'b0;

  // Address and length are held in registers so they stay stable while AxVALID waits
  assign MM_AXI_AWADDR = addr_q;
  assign MM_AXI_ARADDR = addr_q;
  assign MM_AXI_AWLEN  = len_q;
  assign MM_AXI_ARLEN  = len_q;
  assign rd_data       = MM_AXI_RDATA;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, handshake outputs and bookkeeping strobes
  always_comb begin
    state_n        = state;
    req_ready      = '0;
    wr_ready       = '0;
    rd_valid       = '0;
    done           = '0;
    err            = 1'b0;
    rd_last        = 1'b0;
    MM_AXI_AWVALID = 1'b0;
    MM_AXI_ARVALID = 1'b0;
    MM_AXI_WVALID  = 1'b0;
    MM_AXI_WLAST   = 1'b0;
    MM_AXI_BREADY  = 1'b0;
    MM_AXI_RREADY  = 1'b0;
    MM_AXI_WDATA   = wr_data[{gnt, 5'd0} +: 32];
    MM_AXI_WSTRB   = wr_strb[{gnt, 2'd0} +: 4];
    grant_fire     = 1'b0;
    cnt_inc        = 1'b0;
    err_set        = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_valid && !rst) begin
          grant_fire         = 1'b1;
          req_ready[arb_idx] = 1'b1;
          state_n            = req_write[arb_idx] ? S_AW : S_AR;
        end
      end
      S_AR: begin
        MM_AXI_ARVALID = 1'b1;
        if (MM_AXI_ARREADY) state_n = S_R;
      end
      S_R: begin
        MM_AXI_RREADY = 1'b1;
        rd_valid[gnt] = MM_AXI_RVALID;
        rd_last       = MM_AXI_RLAST;
        if (MM_AXI_RVALID) begin
          if (MM_AXI_RRESP != AXI_RESP_OKAY) err_set = 1'b1;
          if (MM_AXI_RLAST) begin
            if (cnt != len_q) err_set = 1'b1;
            state_n = S_DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_AW: begin
        MM_AXI_AWVALID = 1'b1;
        if (MM_AXI_AWREADY) state_n = S_W;
      end
      S_W: begin
        MM_AXI_WVALID = wr_valid[gnt];
        wr_ready[gnt] = MM_AXI_WREADY;
        MM_AXI_WLAST  = (cnt == len_q);
        if (wr_valid[gnt] && MM_AXI_WREADY) begin
          if (cnt == len_q) state_n = S_B;
          else              cnt_inc = 1'b1;
        end
      end
      S_B: begin
        MM_AXI_BREADY = 1'b1;
        if (MM_AXI_BVALID) begin
          if (MM_AXI_BRESP != AXI_RESP_OKAY) err_set = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        done[gnt] = 1'b1;
        err       = err_q;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Grant ownership, round-robin pointer, beat counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= REQ_IMEM;
      last_grant <= REQ_DMEM;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else if (grant_fire) begin
      gnt        <= arb_idx;
      last_grant <= arb_idx;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cnt_inc) cnt   <= cnt + 8'd1;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Burst address and length captured from the winner at grant
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      addr_q <= req_addr[{arb_idx, 5'd0} +: 32];
      len_q  <= req_len[{arb_idx, 3'd0} +: 8];
    end
  end

endmodule
